// File: rtl/simple_pkg.sv
// simple_pkg: shared FSM states, one-hot phase codes and HLT decode for fetch_phase_unit.
package simple_pkg;
    localparam int WORD_W = 16;
    typedef enum logic [2:0] {S_P1, S_P2, S_P3, S_P4, S_P5, S_WAIT, S_HALT} phase_state_e;
    localparam logic [4:0] PH_P1   = 5'b00001;
    localparam logic [4:0] PH_P2   = 5'b00010;
    localparam logic [4:0] PH_P3   = 5'b00100;
    localparam logic [4:0] PH_P4   = 5'b01000;
    localparam logic [4:0] PH_P5   = 5'b10000;
    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [1:0] HLT_OP  = 2'b11;
    localparam logic [3:0] HLT_FN  = 4'b1111;
    function automatic logic is_hlt(logic [WORD_W-1:0] cmd);
        return cmd[15:14] == HLT_OP && cmd[7:4] == HLT_FN;
    endfunction
    function automatic logic [4:0] phase_of(phase_state_e s);
        return s == S_P1 ? PH_P1 : s == S_P2 ? PH_P2 : s == S_P3 ? PH_P3 :
               s == S_P4 ? PH_P4 : s == S_P5 ? PH_P5 : PH_NONE;
    endfunction
endpackage

// File: rtl/fetch_phase_unit.sv
// fetch_phase_unit: five-phase fetch sequencer holding PC and instruction register.
// Define FETCH_STEP_EN to park in WAIT after each instruction until a step pulse.
module fetch_phase_unit
    import simple_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ready,
    input  logic              PC_load,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] COMMAND,
    output logic [WORD_W-1:0] PC,
    output logic [4:0]        phase,
    output logic              halted,
    input  logic              step
);
    phase_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d, cmd_q, cmd_d;

`ifndef FETCH_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cmd_d   = cmd_q;
        case (state_q)
            S_P1: if (imem_ready) begin
                cmd_d   = imem_rdata;
                pc_d    = pc_q + 1'b1;
                state_d = S_P2;
            end
            S_P2: state_d = S_P3;
            S_P3: state_d = S_P4;
            S_P4: state_d = S_P5;
            S_P5: begin
                pc_d = PC_load ? branch_target : pc_q;
`ifdef FETCH_STEP_EN
                state_d = is_hlt(cmd_q) ? S_HALT : S_WAIT;
`else
                state_d = is_hlt(cmd_q) ? S_HALT : S_P1;
`endif
            end
`ifdef FETCH_STEP_EN
            S_WAIT: state_d = step ? S_P1 : S_WAIT;
`else
            S_WAIT: state_d = S_P1;
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_P1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_P1;
            pc_q    <= RESET_PC;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmd_q   <= cmd_d;
        end
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign COMMAND   = cmd_q;
    assign phase     = phase_of(state_q);
    assign halted    = state_q == S_HALT;
endmodule

// File: tb/tb_fetch_phase_unit.sv
// tb_fetch_phase_unit: table-driven directed vectors; each row is applied for one clock edge.
module tb_fetch_phase_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr, imem_rdata = '0, branch_target = '0, COMMAND, PC;
    logic        imem_ready = 1'b0, PC_load = 1'b0, halted, step = 1'b0;
    logic [4:0]  phase;
    int          n_vec = 0, n_bad = 0;

    typedef struct {
        logic        rst, rdy, ld, stp;
        logic [15:0] rdata, tgt;
        logic [4:0]  ph;
        logic [15:0] pc, cmd;
        logic        hlt;
    } vec_t;
    vec_t tbl[$];

    fetch_phase_unit #(.RESET_PC(16'h0010)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .PC_load(PC_load), .branch_target(branch_target),
        .COMMAND(COMMAND), .PC(PC), .phase(phase), .halted(halted), .step(step)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, rdy, input logic [15:0] rdata, input logic ld,
                       input logic [15:0] tgt, input logic stp, input logic [4:0] ph,
                       input logic [15:0] pc, cmd, input logic hlt);
        vec_t v;
        v = '{rst: rst, rdy: rdy, ld: ld, stp: stp, rdata: rdata, tgt: tgt,
              ph: ph, pc: pc, cmd: cmd, hlt: hlt};
        tbl.push_back(v);
    endtask

    task automatic cmp(input int row, input string name, input logic [15:0] act, exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    initial begin
`ifdef FETCH_STEP_EN
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 5'b00001, 16'h0010, 16'h0000, 0);
        add(0, 1, 16'h1000, 0, 16'h0000, 1, 5'b00010, 16'h0011, 16'h1000, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b00100, 16'h0011, 16'h1000, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b01000, 16'h0011, 16'h1000, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 5'b10000, 16'h0011, 16'h1000, 0);
        add(0, 1, 16'h0000, 0, 16'h0000, 0, 5'b00000, 16'h0011, 16'h1000, 0);
        add(0, 1, 16'h0000, 0, 16'h0000, 0, 5'b00000, 16'h0011, 16'h1000, 0);
        add(0, 1, 16'h0000, 0, 16'h0000, 1, 5'b00001, 16'h0011, 16'h1000, 0);
        add(0, 1, 16'h2000, 0, 16'h0000, 0, 5'b00010, 16'h0012, 16'h2000, 0);
`else
        // step held high throughout: it must have no effect in this build
        add(1, 0, 16'h0000, 0, 16'h0000, 1, 5'b00001, 16'h0010, 16'h0000, 0);
        add(0, 1, 16'hC000, 0, 16'h0000, 1, 5'b00010, 16'h0011, 16'hC000, 0);
        add(0, 1, 16'hC000, 0, 16'h0000, 1, 5'b00100, 16'h0011, 16'hC000, 0);
        add(0, 1, 16'hC000, 1, 16'h0040, 1, 5'b01000, 16'h0011, 16'hC000, 0);
        add(0, 1, 16'hC000, 0, 16'h0000, 1, 5'b10000, 16'h0011, 16'hC000, 0);
        add(0, 1, 16'hC000, 0, 16'h0000, 1, 5'b00001, 16'h0011, 16'hC000, 0);
        add(0, 0, 16'hAAAA, 0, 16'h0000, 1, 5'b00001, 16'h0011, 16'hC000, 0);
        add(0, 0, 16'hAAAA, 0, 16'h0000, 1, 5'b00001, 16'h0011, 16'hC000, 0);
        add(0, 0, 16'hAAAA, 0, 16'h0000, 1, 5'b00001, 16'h0011, 16'hC000, 0);
        add(0, 1, 16'h1234, 0, 16'h0000, 1, 5'b00010, 16'h0012, 16'h1234, 0);
        add(0, 1, 16'h5555, 0, 16'h0000, 1, 5'b00100, 16'h0012, 16'h1234, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b01000, 16'h0012, 16'h1234, 0);
        add(0, 0, 16'h0000, 1, 16'h0040, 1, 5'b10000, 16'h0012, 16'h1234, 0);
        add(0, 0, 16'h0000, 1, 16'h0040, 1, 5'b00001, 16'h0040, 16'h1234, 0);
        add(0, 1, 16'h80F0, 0, 16'h0000, 1, 5'b00010, 16'h0041, 16'h80F0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b00100, 16'h0041, 16'h80F0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b01000, 16'h0041, 16'h80F0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b10000, 16'h0041, 16'h80F0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b00001, 16'h0041, 16'h80F0, 0);
        add(0, 1, 16'hC0F0, 0, 16'h0000, 1, 5'b00010, 16'h0042, 16'hC0F0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b00100, 16'h0042, 16'hC0F0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b01000, 16'h0042, 16'hC0F0, 0);
        add(0, 0, 16'h0000, 1, 16'h0080, 1, 5'b10000, 16'h0042, 16'hC0F0, 0);
        add(0, 0, 16'h0000, 1, 16'h0100, 1, 5'b00000, 16'h0100, 16'hC0F0, 1);
        add(0, 1, 16'h1111, 1, 16'h0200, 1, 5'b00000, 16'h0100, 16'hC0F0, 1);
        add(0, 1, 16'h1111, 0, 16'h0000, 1, 5'b00000, 16'h0100, 16'hC0F0, 1);
        add(1, 0, 16'h0000, 0, 16'h0000, 1, 5'b00001, 16'h0010, 16'h0000, 0);
        add(0, 1, 16'h0000, 0, 16'h0000, 1, 5'b00010, 16'h0011, 16'h0000, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b00100, 16'h0011, 16'h0000, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b01000, 16'h0011, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'hFFFF, 1, 5'b10000, 16'h0011, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'hFFFF, 1, 5'b00001, 16'hFFFF, 16'h0000, 0);
        add(0, 1, 16'h2222, 0, 16'h0000, 1, 5'b00010, 16'h0000, 16'h2222, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 5'b00100, 16'h0000, 16'h2222, 0);
        add(1, 0, 16'h0000, 0, 16'h0000, 1, 5'b00001, 16'h0010, 16'h0000, 0);
        add(0, 0, 16'h3333, 0, 16'h0000, 1, 5'b00001, 16'h0010, 16'h0000, 0);
        add(1, 1, 16'h3333, 0, 16'h0000, 1, 5'b00001, 16'h0010, 16'h0000, 0);
        add(0, 1, 16'h3333, 0, 16'h0000, 1, 5'b00010, 16'h0011, 16'h3333, 0);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            reset         = tbl[i].rst;
            imem_ready    = tbl[i].rdy;
            imem_rdata    = tbl[i].rdata;
            PC_load       = tbl[i].ld;
            branch_target = tbl[i].tgt;
            step          = tbl[i].stp;
            @(posedge clk);
            #1;
            n_vec++;
            cmp(i, "phase", {11'd0, phase}, {11'd0, tbl[i].ph});
            cmp(i, "PC", PC, tbl[i].pc);
            cmp(i, "imem_addr", imem_addr, tbl[i].pc);
            cmp(i, "COMMAND", COMMAND, tbl[i].cmd);
            cmp(i, "halted", {15'd0, halted}, {15'd0, tbl[i].hlt});
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
